// File: rtl/arch_defs_pkg.sv
// ---------------------------------------------------------------------------
// arch_defs_pkg
// Shared architecture definitions for the CPU-side peripherals.
//   DATA_WIDTH           : width of a CPU output-port byte
//   uart_tx_buf_state_t  : state encoding of the buffered UART transmitter
//   safe_clog2()         : $clog2 clamped to a minimum of 1 bit, so that
//                          counters and pointers never collapse to zero width
// ---------------------------------------------------------------------------
package arch_defs_pkg;

    localparam int DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        S_UART_TXB_IDLE,
        S_UART_TXB_START,
        S_UART_TXB_DATA,
        S_UART_TXB_STOP
    } uart_tx_buf_state_t;

    function automatic int safe_clog2(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_buffered_if.sv
// ---------------------------------------------------------------------------
// uart_tx_buffered_if
// CPU-side write port and status/line signals of the buffered UART
// transmitter.
//   tx_write_strobe      : enqueue request (master -> slave)
//   tx_parallel_in_data  : byte to enqueue (master -> slave)
//   tx_fifo_full         : FIFO holds FIFO_DEPTH entries (slave -> master)
//   tx_fifo_empty        : FIFO holds no entries (slave -> master)
//   tx_overflow          : sticky dropped-write flag (slave -> master)
//   busy_flag            : transmitter active or data pending (slave -> master)
//   data_out             : serial TX line, idles high (slave -> master)
// ---------------------------------------------------------------------------
interface uart_tx_buffered_if;
    import arch_defs_pkg::*;

    logic                  tx_write_strobe;
    logic [DATA_WIDTH-1:0] tx_parallel_in_data;
    logic                  tx_fifo_full;
    logic                  tx_fifo_empty;
    logic                  tx_overflow;
    logic                  busy_flag;
    logic                  data_out;

    modport master (
        output tx_write_strobe,
        output tx_parallel_in_data,
        input  tx_fifo_full,
        input  tx_fifo_empty,
        input  tx_overflow,
        input  busy_flag,
        input  data_out
    );

    modport slave (
        input  tx_write_strobe,
        input  tx_parallel_in_data,
        output tx_fifo_full,
        output tx_fifo_empty,
        output tx_overflow,
        output busy_flag,
        output data_out
    );

endinterface

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock first-word-fall-through FIFO. Writes while full are dropped;
// fullness is judged on the registered flag, so a write arriving in the same
// cycle as a pop from a full FIFO is still dropped.
//   clk      in   system clock
//   reset    in   asynchronous active-high reset (pointers and count only)
//   wr_en    in   write request
//   wr_data  in   data to write
//   rd_en    in   pop request (ignored while empty)
//   rd_data  out  current head entry, valid whenever empty is low
//   full     out  registered: count == DEPTH
//   empty    out  registered: count == 0
// DEPTH must be a power of two so the pointers wrap by natural overflow.
// ---------------------------------------------------------------------------
module sync_fifo
    import arch_defs_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = safe_clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;

    logic             w_wr_accept;
    logic             w_rd_accept;
    logic [CNT_W-1:0] w_count_next;

    assign w_wr_accept = wr_en && !r_full;
    assign w_rd_accept = rd_en && !r_empty;

    always_comb begin
        w_count_next = r_count;
        case ({w_wr_accept, w_rd_accept})
            2'b10:   w_count_next = r_count + 1'b1;
            2'b01:   w_count_next = r_count - 1'b1;
            default: w_count_next = r_count;
        endcase
    end

    // Storage has no reset so it maps onto plain distributed/block memory.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_accept) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= w_count_next;
            r_full  <= (w_count_next == FULL_COUNT);
            r_empty <= (w_count_next == '0);
        end
    end

    assign rd_data = r_mem[r_rd_ptr];
    assign full    = r_full;
    assign empty   = r_empty;

endmodule

// File: rtl/uart_tx_buffered.sv
// ---------------------------------------------------------------------------
// uart_tx_buffered
// Buffered 8N1 UART transmitter. CPU writes land in a small FIFO; the frame
// serializer drains it continuously, chaining frames back-to-back (STOP's last
// cycle is followed directly by the next START) while data remains.
//   clk    in      system clock
//   reset  in      asynchronous active-high reset; line returns high at once
//                  and all queued bytes are discarded
//   bus    slave   write strobe/data in; FIFO flags, overflow, busy, TX line out
// Parameters: CLOCK_SPEED (Hz), BAUD_RATE (bit/s), FIFO_DEPTH (power of two).
// ---------------------------------------------------------------------------
module uart_tx_buffered
    import arch_defs_pkg::*;
#(
    parameter int CLOCK_SPEED = 2_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                clk,
    input  logic                reset,
    uart_tx_buffered_if.slave   bus
);

    localparam int CLKS_PER_BIT = CLOCK_SPEED / BAUD_RATE;
    localparam int CNT_W        = safe_clog2(CLKS_PER_BIT);
    localparam int IDX_W        = safe_clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    uart_tx_buf_state_t    r_state;
    logic [CNT_W-1:0]      r_clk_cnt;
    logic [IDX_W-1:0]      r_bit_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_data_out;
    logic                  r_overflow;

    logic [DATA_WIDTH-1:0] w_fifo_head;
    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_bit_end;
    logic                  w_pop;

    assign w_bit_end = (r_clk_cnt == LAST_CNT);

    // Pop whenever the serializer is ready for a new byte: straight away in
    // IDLE, or at the end of STOP so the next START follows without a gap.
    assign w_pop = !w_fifo_empty &&
                   ((r_state == S_UART_TXB_IDLE) ||
                    ((r_state == S_UART_TXB_STOP) && w_bit_end));

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (bus.tx_write_strobe),
        .wr_data (bus.tx_parallel_in_data),
        .rd_en   (w_pop),
        .rd_data (w_fifo_head),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    // Uses the registered full flag, matching the FIFO's own drop decision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (bus.tx_write_strobe && w_fifo_full) begin
            r_overflow <= 1'b1;
        end
    end

    // The line level is registered alongside each state transition, so
    // data_out only moves on state or bit boundaries.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_UART_TXB_IDLE;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_data_out <= 1'b1;
        end else begin
            case (r_state)
                S_UART_TXB_IDLE: begin
                    r_clk_cnt  <= '0;
                    r_data_out <= 1'b1;
                    if (!w_fifo_empty) begin
                        r_shift    <= w_fifo_head;
                        r_state    <= S_UART_TXB_START;
                        r_data_out <= 1'b0;
                    end
                end

                S_UART_TXB_START: begin
                    if (w_bit_end) begin
                        r_clk_cnt  <= '0;
                        r_bit_idx  <= '0;
                        r_state    <= S_UART_TXB_DATA;
                        r_data_out <= r_shift[0];
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                S_UART_TXB_DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == LAST_IDX) begin
                            r_state    <= S_UART_TXB_STOP;
                            r_data_out <= 1'b1;
                        end else begin
                            // shift[1] becomes shift[0] after this shift.
                            r_shift    <= r_shift >> 1;
                            r_bit_idx  <= r_bit_idx + 1'b1;
                            r_data_out <= r_shift[1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                S_UART_TXB_STOP: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (!w_fifo_empty) begin
                            r_shift    <= w_fifo_head;
                            r_state    <= S_UART_TXB_START;
                            r_data_out <= 1'b0;
                        end else begin
                            r_state    <= S_UART_TXB_IDLE;
                            r_data_out <= 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state    <= S_UART_TXB_IDLE;
                    r_clk_cnt  <= '0;
                    r_data_out <= 1'b1;
                end
            endcase
        end
    end

    assign bus.tx_fifo_full  = w_fifo_full;
    assign bus.tx_fifo_empty = w_fifo_empty;
    assign bus.tx_overflow   = r_overflow;
    assign bus.busy_flag     = (r_state != S_UART_TXB_IDLE) || !w_fifo_empty;
    assign bus.data_out      = r_data_out;

endmodule
